autoconfig_zii_chain: RTL and testbench
=======================================

// Module: autoconfig_zii_chain
// PURPOSE
//  Zorro II AutoConfig responder for NUM_BOARDS logical boards (RAM, IDE, I/O, ...) presented one at a time behind a single CFGIN_n/CFGOUT_n pair.
//  Serves the inverted-nibble config ROM at $E8xxxx for the active board and latches the base address written by Kickstart.
//  Handles shut-up, then advances to the next board; CFGOUT_n falls after the last board.
//  Fully synchronous to C7M; sits between the CPU bus decode and the RAM/IDE chip-select logic.
// PARAMETERS
//  NUM_BOARDS  2            number of logical boards in the chain (1..8)
//  MFG_ID      16'h082C     manufacturer ID shared by all boards
//  SERIAL      32'h0        serial number shared by all boards
//  ER_TYPE     {4'hD,4'hE}  per-board reg $00 nibble, uninverted, board0 in LSBs (4*N bits)
//  ER_SIZE     {4'h1,4'h0}  per-board reg $02 nibble, uninverted (4*N bits)
//  PROD_ID     {8'd6,8'd8}  per-board product number (8*N bits)
//  ROM_VEC     {16'h1,16'h0} per-board diag ROM offset, used when ER_TYPE[0]=1 (16*N bits)
// PORTS
//  C7M           in   1      7 MHz clock, all logic on rising edge
//  RESET_n       in   1      synchronous active-low reset
//  CFGIN_n       in   1      chain enable from previous slot, low = our turn
//  AS_CPU_n      in   1      CPU address strobe, async, double-synchronised internally
//  DS_n          in   1      data strobe, async, double-synchronised internally
//  RW_n          in   1      1 = read, 0 = write
//  A_HIGH        in   8      A[23:16]
//  A_LOW         in   6      A[6:1]
//  D_IN          in   4      D[15:12] from bus
//  D_OUT         out  4      D[15:12] to bus
//  D_OE          out  1      drive enable for D_OUT (top level builds the inout)
//  BASE_ADDR     out  8*N    per-board A[23:16] base; board0 in LSBs
//  CONFIGURED_n  out  N      per-board, low once a base address is committed
//  CFGOUT_n      out  1      chain enable to next slot
// BEHAVIOUR
//  Reset (RESET_n low at a C7M edge): idx=0, BASE_ADDR=0, CONFIGURED_n all 1, shutup all 0, CFGOUT_n=1, D_OE=0, D_OUT=4'hF, DS/AS edge flags cleared.
//  Reset mid-cycle aborts any pending commit; the whole chain restarts at board 0.
//  acc = !CFGIN_n && !CFGOUT_n_int && A_HIGH==8'hE8 && as_s==0 (as_s, ds_s = 2-FF synced).
//  Read: when acc && RW_n && ds_s==0, D_OE=1 and D_OUT is registered; D_OUT is valid 1 clock after ds_s falls and is held while ds_s stays low.
//    D_OE drops in the same clock that ds_s rises or acc drops.
//  Read map (addr = A_LOW*2) for board idx:
//    $00=ER_TYPE; $02=ER_SIZE; $04/$06=~PROD_ID nibbles; $08=~4'b1100; $0A=~0;
//    $10-$16=~MFG_ID; $18-$26=~SERIAL msb first; $28-$2E=~ROM_VEC if ER_TYPE[0] else 4'hF;
//    $40/$42=4'h0; all other addresses=4'hF.
//  Write: acted on once per falling edge of ds_s (edge-detected, single strobe) when acc && !RW_n.
//    $4A: low nibble of BASE_ADDR[idx] <= D_IN.
//    $48: high nibble of BASE_ADDR[idx] <= D_IN, then CONFIGURED_n[idx] <= 0.
//    $4C: shutup[idx] <= 1; BASE_ADDR and CONFIGURED_n unchanged.
//    A repeat write to $48 on an already-configured board is ignored.
//  Advance: a board is done when CONFIGURED_n[idx]==0 or shutup[idx]==1.
//    On the rising edge of as_s with the board done: idx<=idx+1.
//    If idx was NUM_BOARDS-1, idx holds and CFGOUT_n<=0 (registered).
//  CFGOUT_n stays 0 until reset. After that, acc is false and D_OE stays 0.
//  CFGIN_n high: no reads or writes; idx, done flags and edge detectors are held.
//    An AS rising edge while CFGIN_n is high does not advance idx.
//  Simultaneous $48 write and AS rise are impossible within one bus cycle; the commit always precedes the advance by >=1 clock.
// TESTING
//  T1 reset, CFGIN_n=0, read $00,$02,$04,$06 for board0 -> 4'hE,4'h0,4'hF,4'h7; D_OE only while DS_n low.
//  T2 write $4A=4'h0 then $48=4'h2 -> BASE_ADDR[7:0]=8'h20, CONFIGURED_n[0]=0; next AS rise -> $00 reads 4'hD (board1).
//  T3 board1 write $4C -> CONFIGURED_n[1]=1; AS rise -> CFGOUT_n=0; $E80000 reads give D_OE=0.
//  T4 CFGIN_n=1 throughout any $E8 read or write -> D_OE=0; no state change; CFGOUT_n stays 1.
//  T5 DS_n held low for 10 clocks on a $48 write -> exactly one commit; a second $48 write with a different value is ignored.
//  T6 RESET_n low for 1 clock after board0 is configured -> all outputs at reset values; sequence restarts at board0.

Source files
------------

// File: rtl/autoconfig_zii_chain_if.sv
// Zorro II CPU-side bus bundle seen by the AutoConfig responder.
//   AS_CPU_n, DS_n, RW_n : bus strobes and direction (asynchronous to C7M)
//   A_HIGH, A_LOW        : A[23:16] and A[6:1]
//   D_IN                 : D[15:12] driven by the bus
//   D_OUT, D_OE          : D[15:12] returned by the responder and its drive enable
// master = CPU/bus side, slave = responder.
interface autoconfig_zii_chain_if;
  logic       AS_CPU_n;
  logic       DS_n;
  logic       RW_n;
  logic [7:0] A_HIGH;
  logic [5:0] A_LOW;
  logic [3:0] D_IN;
  logic [3:0] D_OUT;
  logic       D_OE;

  modport master (
    output AS_CPU_n, DS_n, RW_n, A_HIGH, A_LOW, D_IN,
    input  D_OUT, D_OE
  );

  modport slave (
    input  AS_CPU_n, DS_n, RW_n, A_HIGH, A_LOW, D_IN,
    output D_OUT, D_OE
  );
endinterface

// File: rtl/autoconfig_zii_chain.sv
// Zorro II AutoConfig responder presenting NUM_BOARDS logical boards, one at a
// time, behind a single CFGIN_n/CFGOUT_n slot pair.
//   C7M          : 7 MHz clock, rising edge
//   RESET_n      : synchronous active-low reset
//   CFGIN_n      : low when the previous slot has finished configuring
//   bus          : CPU strobes, address, data in/out and data drive enable
//   BASE_ADDR    : per-board A[23:16] base, board 0 in the LSBs
//   CONFIGURED_n : per-board, low once a base address has been committed
//   CFGOUT_n     : low once every board is configured or shut up
module autoconfig_zii_chain #(
  parameter int unsigned                  NUM_BOARDS = 2,
  parameter logic [15:0]                  MFG_ID     = 16'h082C,
  parameter logic [31:0]                  SERIAL     = 32'h0,
  parameter logic [4*NUM_BOARDS-1:0]      ER_TYPE    = {4'hD, 4'hE},
  parameter logic [4*NUM_BOARDS-1:0]      ER_SIZE    = {4'h1, 4'h0},
  parameter logic [8*NUM_BOARDS-1:0]      PROD_ID    = {8'd6, 8'd8},
  parameter logic [16*NUM_BOARDS-1:0]     ROM_VEC    = {16'h1, 16'h0}
) (
  input  logic                        C7M,
  input  logic                        RESET_n,
  input  logic                        CFGIN_n,
  autoconfig_zii_chain_if.slave       bus,
  output logic [8*NUM_BOARDS-1:0]     BASE_ADDR,
  output logic [NUM_BOARDS-1:0]       CONFIGURED_n,
  output logic                        CFGOUT_n
);

  localparam int unsigned IDX_W = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

  // Register indices are byte offsets / 2 (A[6:1]).
  localparam logic [5:0] REG_BASE_HI = 6'h24;  // $48
  localparam logic [5:0] REG_BASE_LO = 6'h25;  // $4A
  localparam logic [5:0] REG_SHUTUP  = 6'h26;  // $4C

  logic                    as_meta_q, as_meta_d, as_s_q, as_s_d;
  logic                    ds_meta_q, ds_meta_d, ds_s_q, ds_s_d;
  logic                    as_prev_q, as_prev_d, ds_prev_q, ds_prev_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [8*NUM_BOARDS-1:0] base_q, base_d;
  logic [NUM_BOARDS-1:0]   configured_n_q, configured_n_d;
  logic [NUM_BOARDS-1:0]   shutup_q, shutup_d;
  logic                    cfgout_n_q, cfgout_n_d;
  logic [3:0]              dout_q, dout_d;

  logic       acc_c, read_en_c, wr_stb_c, as_rise_c, done_c;
  logic [3:0] er_type_c, er_size_c;
  logic [7:0] prod_id_c;
  logic [15:0] rom_vec_c;

  // Config ROM contents for one board; most registers are stored inverted.
  function automatic logic [3:0] rom_nibble(input logic [5:0]  r,
                                            input logic [3:0]  et,
                                            input logic [3:0]  es,
                                            input logic [7:0]  pid,
                                            input logic [15:0] rv);
    logic [15:0] mfg_sh;
    logic [31:0] ser_sh;
    logic [15:0] rv_sh;
    logic [2:0]  ser_off;
    logic [15:0] mfg_inv;
    logic [31:0] ser_inv;
    logic [15:0] rv_inv;
    mfg_inv = ~MFG_ID;
    ser_inv = ~SERIAL;
    rv_inv  = ~rv;
    ser_off = 3'(r - 6'd12);
    mfg_sh  = mfg_inv << {r[1:0], 2'b00};
    ser_sh  = ser_inv << {ser_off, 2'b00};
    rv_sh   = rv_inv << {r[1:0], 2'b00};
    if (r == 6'd0)                        return et;
    else if (r == 6'd1)                   return es;
    else if (r == 6'd2)                   return ~pid[7:4];
    else if (r == 6'd3)                   return ~pid[3:0];
    else if (r == 6'd4)                   return ~4'b1100;
    else if (r == 6'd5)                   return 4'hF;
    else if (r >= 6'd8 && r <= 6'd11)     return mfg_sh[15:12];
    else if (r >= 6'd12 && r <= 6'd19)    return ser_sh[31:28];
    else if (r >= 6'd20 && r <= 6'd23)    return et[0] ? rv_sh[15:12] : 4'hF;
    else if (r == 6'd32 || r == 6'd33)    return 4'h0;
    else                                  return 4'hF;
  endfunction

  // Parameters of the board currently presented on the bus.
  assign er_type_c = ER_TYPE[4*idx_q +: 4];
  assign er_size_c = ER_SIZE[4*idx_q +: 4];
  assign prod_id_c = PROD_ID[8*idx_q +: 8];
  assign rom_vec_c = ROM_VEC[16*idx_q +: 16];

  assign acc_c     = !CFGIN_n && cfgout_n_q && (bus.A_HIGH == 8'hE8) && !as_s_q;
  assign read_en_c = acc_c && bus.RW_n && !ds_s_q;
  assign wr_stb_c  = acc_c && !bus.RW_n && ds_prev_q && !ds_s_q;
  // Advance only counts AS rising while the chain is enabled and unfinished.
  assign as_rise_c = !CFGIN_n && cfgout_n_q && !as_prev_q && as_s_q;
  assign done_c    = !configured_n_q[idx_q] || shutup_q[idx_q];

  // Next-state: synchronisers, edge history, ROM read, config writes, advance.
  always_comb begin
    as_meta_d      = bus.AS_CPU_n;
    as_s_d         = as_meta_q;
    ds_meta_d      = bus.DS_n;
    ds_s_d         = ds_meta_q;
    as_prev_d      = as_prev_q;
    ds_prev_d      = ds_prev_q;
    idx_d          = idx_q;
    base_d         = base_q;
    configured_n_d = configured_n_q;
    shutup_d       = shutup_q;
    cfgout_n_d     = cfgout_n_q;
    dout_d         = 4'hF;

    // Edge history freezes while the slot is not enabled.
    if (!CFGIN_n) begin
      as_prev_d = as_s_q;
      ds_prev_d = ds_s_q;
    end

    if (read_en_c) begin
      dout_d = rom_nibble(bus.A_LOW, er_type_c, er_size_c, prod_id_c, rom_vec_c);
    end

    // A committed base address is frozen until reset.
    if (wr_stb_c) begin
      if (bus.A_LOW == REG_BASE_LO && configured_n_q[idx_q]) begin
        base_d[8*idx_q +: 4] = bus.D_IN;
      end else if (bus.A_LOW == REG_BASE_HI && configured_n_q[idx_q]) begin
        base_d[8*idx_q + 4 +: 4] = bus.D_IN;
        configured_n_d[idx_q]    = 1'b0;
      end else if (bus.A_LOW == REG_SHUTUP) begin
        shutup_d[idx_q] = 1'b1;
      end
    end

    if (as_rise_c && done_c) begin
      if (idx_q == IDX_W'(NUM_BOARDS - 1)) begin
        cfgout_n_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // State register; strobes idle high so reset leaves no pending edge.
  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      as_meta_q      <= 1'b1;
      as_s_q         <= 1'b1;
      ds_meta_q      <= 1'b1;
      ds_s_q         <= 1'b1;
      as_prev_q      <= 1'b1;
      ds_prev_q      <= 1'b1;
      idx_q          <= '0;
      base_q         <= '0;
      configured_n_q <= '1;
      shutup_q       <= '0;
      cfgout_n_q     <= 1'b1;
      dout_q         <= 4'hF;
    end else begin
      as_meta_q      <= as_meta_d;
      as_s_q         <= as_s_d;
      ds_meta_q      <= ds_meta_d;
      ds_s_q         <= ds_s_d;
      as_prev_q      <= as_prev_d;
      ds_prev_q      <= ds_prev_d;
      idx_q          <= idx_d;
      base_q         <= base_d;
      configured_n_q <= configured_n_d;
      shutup_q       <= shutup_d;
      cfgout_n_q     <= cfgout_n_d;
      dout_q         <= dout_d;
    end
  end

  // Drive enable releases in the same clock the strobe or select goes away.
  assign bus.D_OUT    = dout_q;
  assign bus.D_OE     = read_en_c;
  assign BASE_ADDR    = base_q;
  assign CONFIGURED_n = configured_n_q;
  assign CFGOUT_n     = cfgout_n_q;

endmodule

// File: tb/tb_autoconfig_zii_chain.sv
// Directed bench for autoconfig_zii_chain with the default two-board chain.
module tb_autoconfig_zii_chain;

  logic        C7M;
  logic        RESET_n;
  logic        CFGIN_n;
  logic [15:0] base_addr;
  logic [1:0]  configured_n;
  logic        cfgout_n;

  int n_cmp;
  int n_err;

  autoconfig_zii_chain_if bus ();

  autoconfig_zii_chain dut (
    .C7M          (C7M),
    .RESET_n      (RESET_n),
    .CFGIN_n      (CFGIN_n),
    .bus          (bus),
    .BASE_ADDR    (base_addr),
    .CONFIGURED_n (configured_n),
    .CFGOUT_n     (cfgout_n)
  );

  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge C7M);
  endtask

  task automatic apply_reset(input int cycles);
    bus.AS_CPU_n = 1'b1;
    bus.DS_n     = 1'b1;
    bus.RW_n     = 1'b1;
    RESET_n      = 1'b0;
    tick(cycles);
    RESET_n = 1'b1;
    tick(1);
  endtask

  task automatic as_begin();
    bus.A_HIGH   = 8'hE8;
    bus.AS_CPU_n = 1'b0;
    tick(3);
  endtask

  task automatic as_end();
    bus.AS_CPU_n = 1'b1;
    tick(4);
  endtask

  // One data strobe inside an open address strobe; samples D_OUT/D_OE while
  // DS_n is low and D_OE again once DS_n has been high for a while.
  task automatic strobe(input logic rw, input logic [6:0] addr, input logic [3:0] d,
                        input int hold, output logic [3:0] dout, output logic oe,
                        output logic oe_after);
    bus.A_LOW = addr[6:1];
    bus.RW_n  = rw;
    bus.D_IN  = d;
    bus.DS_n  = 1'b0;
    tick(hold);
    dout     = bus.D_OUT;
    oe       = bus.D_OE;
    bus.DS_n = 1'b1;
    tick(4);
    oe_after = bus.D_OE;
    bus.RW_n = 1'b1;
  endtask

  task automatic wr(input logic [6:0] addr, input logic [3:0] d, input int hold);
    logic [3:0] dd;
    logic       o1, o2;
    strobe(1'b0, addr, d, hold, dd, o1, o2);
  endtask

  task automatic test_reset();
    apply_reset(3);
    n_cmp++; if (base_addr !== 16'h0000) begin n_err++; $display("FAIL reset_base: got %h want 0000", base_addr); end
    n_cmp++; if (configured_n !== 2'b11) begin n_err++; $display("FAIL reset_configured: got %b want 11", configured_n); end
    n_cmp++; if (cfgout_n !== 1'b1) begin n_err++; $display("FAIL reset_cfgout: got %b want 1", cfgout_n); end
    n_cmp++; if (bus.D_OE !== 1'b0) begin n_err++; $display("FAIL reset_doe: got %b want 0", bus.D_OE); end
    n_cmp++; if (bus.D_OUT !== 4'hF) begin n_err++; $display("FAIL reset_dout: got %h want F", bus.D_OUT); end
  endtask

  // Board 0 ROM walk: type E, size 0, product 8, MFG 082C, serial 0, no diag ROM.
  task automatic test_board0_read();
    logic [6:0] addrs [15] = '{7'h00, 7'h02, 7'h04, 7'h06, 7'h08, 7'h0A, 7'h10, 7'h12,
                               7'h14, 7'h16, 7'h18, 7'h28, 7'h30, 7'h40, 7'h42};
    logic [3:0] exps  [15] = '{4'hE, 4'h0, 4'hF, 4'h7, 4'h3, 4'hF, 4'hF, 4'h7,
                               4'hD, 4'h3, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
    logic [3:0] dout;
    logic       oe, oe_after;
    as_begin();
    for (int i = 0; i < 15; i++) begin
      strobe(1'b1, addrs[i], 4'h0, 4, dout, oe, oe_after);
      n_cmp++; if (dout !== exps[i]) begin n_err++; $display("FAIL b0_read_%h: got %h want %h", addrs[i], dout, exps[i]); end
      n_cmp++; if (oe !== 1'b1) begin n_err++; $display("FAIL b0_oe_%h: got %b want 1", addrs[i], oe); end
      n_cmp++; if (oe_after !== 1'b0) begin n_err++; $display("FAIL b0_oe_release_%h: got %b want 0", addrs[i], oe_after); end
    end
    as_end();
  endtask

  task automatic test_config_board0();
    logic [3:0] dout;
    logic       oe, oe_after;
    as_begin();
    wr(7'h4A, 4'h0, 4);
    as_end();
    n_cmp++; if (configured_n !== 2'b11) begin n_err++; $display("FAIL lo_only_configured: got %b want 11", configured_n); end
    as_begin();
    wr(7'h48, 4'h2, 4);
    n_cmp++; if (base_addr[7:0] !== 8'h20) begin n_err++; $display("FAIL b0_base: got %h want 20", base_addr[7:0]); end
    n_cmp++; if (configured_n !== 2'b10) begin n_err++; $display("FAIL b0_configured: got %b want 10", configured_n); end
    as_end();
    as_begin();
    strobe(1'b1, 7'h00, 4'h0, 4, dout, oe, oe_after);
    n_cmp++; if (dout !== 4'hD) begin n_err++; $display("FAIL b1_type: got %h want D", dout); end
    strobe(1'b1, 7'h28, 4'h0, 4, dout, oe, oe_after);
    n_cmp++; if (dout !== 4'hF) begin n_err++; $display("FAIL b1_romvec_28: got %h want F", dout); end
    strobe(1'b1, 7'h2E, 4'h0, 4, dout, oe, oe_after);
    n_cmp++; if (dout !== 4'hE) begin n_err++; $display("FAIL b1_romvec_2e: got %h want E", dout); end
    as_end();
    n_cmp++; if (cfgout_n !== 1'b1) begin n_err++; $display("FAIL b1_not_done_cfgout: got %b want 1", cfgout_n); end
  endtask

  task automatic test_shutup_board1();
    logic [3:0] dout;
    logic       oe, oe_after;
    as_begin();
    wr(7'h4C, 4'h0, 4);
    as_end();
    n_cmp++; if (configured_n !== 2'b10) begin n_err++; $display("FAIL shutup_configured: got %b want 10", configured_n); end
    n_cmp++; if (base_addr !== 16'h0020) begin n_err++; $display("FAIL shutup_base: got %h want 0020", base_addr); end
    n_cmp++; if (cfgout_n !== 1'b0) begin n_err++; $display("FAIL chain_cfgout: got %b want 0", cfgout_n); end
    as_begin();
    strobe(1'b1, 7'h00, 4'h0, 4, dout, oe, oe_after);
    n_cmp++; if (oe !== 1'b0) begin n_err++; $display("FAIL after_chain_oe: got %b want 0", oe); end
    as_end();
    n_cmp++; if (cfgout_n !== 1'b0) begin n_err++; $display("FAIL cfgout_sticky: got %b want 0", cfgout_n); end
  endtask

  task automatic test_cfgin_high();
    logic [3:0] dout;
    logic       oe, oe_after;
    apply_reset(2);
    CFGIN_n = 1'b1;
    tick(2);
    as_begin();
    strobe(1'b1, 7'h00, 4'h0, 4, dout, oe, oe_after);
    n_cmp++; if (oe !== 1'b0) begin n_err++; $display("FAIL cfgin_oe: got %b want 0", oe); end
    wr(7'h4A, 4'h7, 4);
    wr(7'h48, 4'h9, 4);
    wr(7'h4C, 4'h0, 4);
    as_end();
    n_cmp++; if (base_addr !== 16'h0000) begin n_err++; $display("FAIL cfgin_base: got %h want 0000", base_addr); end
    n_cmp++; if (configured_n !== 2'b11) begin n_err++; $display("FAIL cfgin_configured: got %b want 11", configured_n); end
    n_cmp++; if (cfgout_n !== 1'b1) begin n_err++; $display("FAIL cfgin_cfgout: got %b want 1", cfgout_n); end
    // Configure board 0, then cycle AS with the slot disabled: no advance.
    CFGIN_n = 1'b0;
    tick(2);
    as_begin();
    wr(7'h4A, 4'h1, 4);
    wr(7'h48, 4'h4, 4);
    CFGIN_n = 1'b1;
    tick(2);
    bus.AS_CPU_n = 1'b1;
    tick(4);
    bus.AS_CPU_n = 1'b0;
    tick(4);
    CFGIN_n = 1'b0;
    tick(2);
    strobe(1'b1, 7'h00, 4'h0, 4, dout, oe, oe_after);
    n_cmp++; if (dout !== 4'hE) begin n_err++; $display("FAIL cfgin_no_advance: got %h want E", dout); end
    as_end();
    as_begin();
    strobe(1'b1, 7'h00, 4'h0, 4, dout, oe, oe_after);
    n_cmp++; if (dout !== 4'hD) begin n_err++; $display("FAIL cfgin_then_advance: got %h want D", dout); end
    as_end();
    n_cmp++; if (base_addr !== 16'h0041) begin n_err++; $display("FAIL cfgin_b0_base: got %h want 0041", base_addr); end
  endtask

  task automatic test_single_commit();
    apply_reset(2);
    as_begin();
    wr(7'h4A, 4'h5, 4);
    wr(7'h48, 4'h3, 10);
    n_cmp++; if (base_addr !== 16'h0035) begin n_err++; $display("FAIL long_ds_base: got %h want 0035", base_addr); end
    wr(7'h48, 4'h9, 4);
    wr(7'h4A, 4'hA, 4);
    n_cmp++; if (base_addr !== 16'h0035) begin n_err++; $display("FAIL repeat_48_ignored: got %h want 0035", base_addr); end
    n_cmp++; if (configured_n !== 2'b10) begin n_err++; $display("FAIL repeat_configured: got %b want 10", configured_n); end
    as_end();
    n_cmp++; if (base_addr !== 16'h0035) begin n_err++; $display("FAIL advance_base: got %h want 0035", base_addr); end
  endtask

  task automatic test_reset_restart();
    logic [3:0] dout;
    logic       oe, oe_after;
    RESET_n = 1'b0;
    tick(1);
    RESET_n = 1'b1;
    tick(1);
    n_cmp++; if (base_addr !== 16'h0000) begin n_err++; $display("FAIL rst2_base: got %h want 0000", base_addr); end
    n_cmp++; if (configured_n !== 2'b11) begin n_err++; $display("FAIL rst2_configured: got %b want 11", configured_n); end
    n_cmp++; if (cfgout_n !== 1'b1) begin n_err++; $display("FAIL rst2_cfgout: got %b want 1", cfgout_n); end
    n_cmp++; if (bus.D_OUT !== 4'hF) begin n_err++; $display("FAIL rst2_dout: got %h want F", bus.D_OUT); end
    n_cmp++; if (bus.D_OE !== 1'b0) begin n_err++; $display("FAIL rst2_doe: got %b want 0", bus.D_OE); end
    as_begin();
    strobe(1'b1, 7'h00, 4'h0, 4, dout, oe, oe_after);
    n_cmp++; if (dout !== 4'hE) begin n_err++; $display("FAIL rst2_board0_type: got %h want E", dout); end
    n_cmp++; if (oe !== 1'b1) begin n_err++; $display("FAIL rst2_board0_oe: got %b want 1", oe); end
    as_end();
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    RESET_n      = 1'b0;
    CFGIN_n      = 1'b0;
    bus.AS_CPU_n = 1'b1;
    bus.DS_n     = 1'b1;
    bus.RW_n     = 1'b1;
    bus.A_HIGH   = 8'h00;
    bus.A_LOW    = 6'h00;
    bus.D_IN     = 4'h0;
    tick(1);
    test_reset();
    test_board0_read();
    test_config_board0();
    test_shutup_board1();
    test_cfgin_high();
    test_single_commit();
    test_reset_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
